aes_dec_ctrl: RTL and testbench



---
 rtl/aes_dec_ctrl_if.sv | 40 ++++
 rtl/aes_dec_ctrl.sv | 121 ++++++++++++
 tb/tb_aes_dec_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_ctrl_if.sv
// Bundle of every signal between the AES decryption round controller and its
// neighbours (block source, key store, round datapath, plaintext consumer).
//   master : the controller itself (aes_dec_ctrl)
//   slave  : the surrounding environment (source, key store, datapath, sink)
// Signals:
//   in_valid/in_ready/in_data     ciphertext handshake and block
//   key_idx/key_data/key_valid    round-key request, same-cycle key, key usable
//   dp_state/dp_key/dp_last       operands for the external round datapath
//   dp_result                     combinational round result
//   out_valid/out_ready/out_data  plaintext handshake and block
//   busy                          controller is not idle
interface aes_dec_ctrl_if;
  localparam int unsigned BLK_W = 128;
  localparam int unsigned IDX_W = 4;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_data;
  logic [IDX_W-1:0] key_idx;
  logic [BLK_W-1:0] key_data;
  logic             key_valid;
  logic [BLK_W-1:0] dp_state;
  logic [BLK_W-1:0] dp_key;
  logic             dp_last;
  logic [BLK_W-1:0] dp_result;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_data;
  logic             busy;

  modport master (
    input  in_valid, in_data, key_data, key_valid, dp_result, out_ready,
    output in_ready, key_idx, dp_state, dp_key, dp_last, out_valid, out_data, busy
  );

  modport slave (
    output in_valid, in_data, key_data, key_valid, dp_result, out_ready,
    input  in_ready, key_idx, dp_state, dp_key, dp_last, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_dec_ctrl.sv
// AES inverse-cipher round controller. Takes a ciphertext block, applies the
// initial AddRoundKey with key NR, then steps an external round datapath
// through rounds NR-1 .. 0 (last round flagged via dp_last), stalling whenever
// the key store deasserts key_valid, and presents the plaintext until taken.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset, discards any block in flight
//   bus  - aes_dec_ctrl_if.master (handshakes, key store, datapath, status)
module aes_dec_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic           clk,
  input  logic           rst,
  aes_dec_ctrl_if.master bus
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned CNT_W = 4;

  localparam logic [CNT_W-1:0] NR_IDX = CNT_W'(NR);
  localparam logic [CNT_W-1:0] NR_M1  = CNT_W'(NR - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  // One-hot controller states
  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_ROUND = 3'b010;
  localparam logic [2:0] S_DONE  = 3'b100;

  logic [2:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [BLK_W-1:0] data_q,      data_d;
  logic [CNT_W-1:0] key_idx_q,   key_idx_d;
  logic             dp_last_q,   dp_last_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;

  // Next state, datapath capture, and status outputs decoded from next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        // Accept only when the round-NR key is usable in the same cycle
        if (bus.in_valid && bus.key_valid) begin
          data_d  = bus.in_data ^ bus.key_data;
          cnt_d   = NR_M1;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (bus.key_valid) begin
          data_d = bus.dp_result;
          // Counter parks at zero rather than wrapping
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs registered: derive their values from the upcoming state
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    key_idx_d   = NR_IDX;
    dp_last_d   = 1'b0;
    if (state_d == S_ROUND) begin
      key_idx_d = cnt_d;
      dp_last_d = (cnt_d == '0);
    end else if (state_d == S_DONE) begin
      key_idx_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      key_idx_q   <= NR_IDX;
      dp_last_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      key_idx_q   <= key_idx_d;
      dp_last_q   <= dp_last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.key_idx   = key_idx_q;
  assign bus.dp_last   = dp_last_q;
  assign bus.dp_state  = data_q;
  assign bus.out_data  = data_q;
  // Key passes straight to the datapath so the key store read stays single-cycle
  assign bus.dp_key    = bus.key_data;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Self-checking bench for aes_dec_ctrl: models the key store (expanded
// AES-128 schedule) and the inverse round datapath, then checks a per-cycle
// vector table, FIPS-197 C.1 sequences, and randomized traffic.
module tb_aes_dec_ctrl;
  localparam int unsigned NR = 10;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [127:0] rk [16];

  always #5 clk = ~clk;

  aes_dec_ctrl_if bus ();

  aes_dec_ctrl #(.NR(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // ---------------- AES arithmetic (pure functions) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x; r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return (x == 8'h00) ? 8'h00 : r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
  // InvMixColumns unless it is the final round.
  function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [127:0] k,
                                             input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] s0, s1, s2, s3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = st[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r + 4*((c + r) % 4)] = b[r + 4*c];
    for (int i = 0; i < 16; i++) t[i] = isbox(t[i]) ^ k[127-8*i -: 8];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        s0 = t[4*c]; s1 = t[4*c+1]; s2 = t[4*c+2]; s3 = t[4*c+3];
        t[4*c]   = gmul(s0,8'h0e) ^ gmul(s1,8'h0b) ^ gmul(s2,8'h0d) ^ gmul(s3,8'h09);
        t[4*c+1] = gmul(s0,8'h09) ^ gmul(s1,8'h0e) ^ gmul(s2,8'h0b) ^ gmul(s3,8'h0d);
        t[4*c+2] = gmul(s0,8'h0d) ^ gmul(s1,8'h09) ^ gmul(s2,8'h0e) ^ gmul(s3,8'h0b);
        t[4*c+3] = gmul(s0,8'h0b) ^ gmul(s1,8'h0d) ^ gmul(s2,8'h09) ^ gmul(s3,8'h0e);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  // Whole-block reference decryption
  function automatic logic [127:0] inv_cipher(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[NR];
    for (int r = NR - 1; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
    return s;
  endfunction

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Key store and round datapath models
  assign bus.key_data  = (bus.key_idx <= 4'(NR)) ? rk[bus.key_idx] : 128'h0;
  assign bus.dp_result = inv_round(bus.dp_state, bus.dp_key, bus.dp_last);

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 128'(bus.in_ready), 128'(1));
    chk({tag, "_idle_ov"},    128'(bus.out_valid), 128'(0));
  endtask

  // Accept one block, walk it to DONE (optionally stalling at one key index),
  // and check key sequence, latency and plaintext. Leaves the DUT in DONE.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input int stall_idx,
                           input int stall_n, input int exp_lat, input string tag);
    int n, exp_k, kerr, stalled;
    logic seen;
    logic [127:0] held;
    n = 0; kerr = 0; stalled = 0; seen = 1'b0; held = '0;
    chk({tag, "_pre_ki"},    128'(bus.key_idx), 128'(NR));
    chk({tag, "_pre_ready"}, 128'(bus.in_ready), 128'(1));
    bus.in_data = ct; bus.in_valid = 1'b1; bus.key_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_k = NR - 1;
    while (!bus.out_valid && n < 64) begin
      if (bus.key_idx !== 4'(exp_k) || bus.dp_last !== (exp_k == 0)) kerr++;
      if (exp_k == stall_idx) begin
        if (!seen) begin held = bus.dp_state; seen = 1'b1; end
        else if (bus.dp_state !== held) kerr++;
      end
      if (exp_k == stall_idx && stalled < stall_n) begin
        bus.key_valid = 1'b0; stalled++;
      end else begin
        bus.key_valid = 1'b1;
        if (exp_k > 0) exp_k--;
      end
      @(posedge clk); #1; n++;
    end
    bus.key_valid = 1'b1;
    chk({tag, "_keyseq_errs"}, 128'(kerr), 128'(0));
    chk({tag, "_latency"},     128'(n), 128'(exp_lat));
    chk({tag, "_out_valid"},   128'(bus.out_valid), 128'(1));
    chk({tag, "_out_data"},    bus.out_data, pt);
    chk({tag, "_done_ki"},     128'(bus.key_idx), 128'(0));
  endtask

  // ---------------- per-cycle vector table ----------------
  typedef struct {
    logic       rst, iv, kv, ordy;
    logic       exp_ir, exp_ov, exp_busy, exp_dl;
    logic [3:0] exp_ki;
    logic       chk_pt;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic iv, input logic kv, input logic ordy,
                         input logic ir, input logic ov, input logic bz, input logic dl,
                         input int ki, input logic cp);
    vec_t v;
    v.rst = r; v.iv = iv; v.kv = kv; v.ordy = ordy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_busy = bz; v.exp_dl = dl;
    v.exp_ki = 4'(ki); v.chk_pt = cp;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m_ph, m_left, n;
    logic iv, kv, ordy;
    logic [127:0] d, m_pt, ct2;
    logic [3:0] m_ki;

    key_expand(C1_KEY);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.key_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;

    // Table: reset, stalled offer, accept, rounds with one stall, DONE hold, release
    //       rst iv kv or  ir ov bz dl ki   cp
    add_vec(1, 1, 1, 1,  1, 0, 0, 0, NR,  0);
    add_vec(0, 1, 0, 0,  1, 0, 0, 0, NR,  0);
    add_vec(0, 1, 1, 0,  0, 0, 1, 0, 9,   0);
    add_vec(0, 1, 1, 1,  0, 0, 1, 0, 8,   0);
    for (int k = 7; k >= 5; k--) add_vec(0, 0, 1, 0, 0, 0, 1, 0, k, 0);
    add_vec(0, 0, 0, 0,  0, 0, 1, 0, 5,   0);
    for (int k = 4; k >= 0; k--) add_vec(0, 0, 1, 0, 0, 0, 1, k == 0, k, 0);
    add_vec(0, 1, 1, 0,  0, 1, 1, 0, 0,   1);
    add_vec(0, 1, 1, 0,  0, 1, 1, 0, 0,   1);
    add_vec(0, 0, 1, 1,  1, 0, 0, 0, NR,  0);
    add_vec(0, 0, 1, 1,  1, 0, 0, 0, NR,  0);

    bus.in_data = C1_CT;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; bus.in_valid = vecs[i].iv;
      bus.key_valid = vecs[i].kv; bus.out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_in_ready", i),  128'(bus.in_ready),  128'(vecs[i].exp_ir));
      chk($sformatf("vec%0d_out_valid", i), 128'(bus.out_valid), 128'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_busy", i),      128'(bus.busy),      128'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_dp_last", i),   128'(bus.dp_last),   128'(vecs[i].exp_dl));
      chk($sformatf("vec%0d_key_idx", i),   128'(bus.key_idx),   128'(vecs[i].exp_ki));
      if (vecs[i].rst) chk($sformatf("vec%0d_out_data", i), bus.out_data, 128'h0);
      if (vecs[i].chk_pt) chk($sformatf("vec%0d_pt", i), bus.out_data, C1_PT);
    end
    rst = 1'b0; bus.in_valid = 1'b0; bus.key_valid = 1'b1; bus.out_ready = 1'b0;

    // FIPS-197 C.1, no stalls: 10-cycle latency
    run_block(C1_CT, C1_PT, -1, 0, NR, "c1");
    release_out("c1");

    // Same vector, 3 stall cycles at key index 5: 13-cycle latency
    run_block(C1_CT, C1_PT, 5, 3, NR + 3, "c1stall");
    release_out("c1stall");

    // Backpressure in DONE with a competing second block offered
    ct2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_block(C1_CT, C1_PT, -1, 0, NR, "bp1");
    bus.in_data = ct2; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_ov", c),    128'(bus.out_valid), 128'(1));
      chk($sformatf("bp_hold%0d_data", c),  bus.out_data, C1_PT);
      chk($sformatf("bp_hold%0d_ready", c), 128'(bus.in_ready), 128'(0));
    end
    release_out("bp1");
    run_block(ct2, inv_cipher(ct2), -1, 0, NR, "bp2");
    release_out("bp2");

    // Reset mid-ROUND at key index 4, with in_valid high on the reset edge
    bus.in_data = C1_CT; bus.in_valid = 1'b1; bus.key_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.key_idx != 4'd4 && n < 20) begin @(posedge clk); #1; n++; end
    chk("rst_reach_ki4", 128'(bus.key_idx), 128'(4));
    rst = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy",      128'(bus.busy),      128'(0));
    chk("rst_key_idx",   128'(bus.key_idx),   128'(NR));
    chk("rst_dp_last",   128'(bus.dp_last),   128'(0));
    chk("rst_out_data",  bus.out_data,        128'h0);
    run_block(C1_CT, C1_PT, -1, 0, NR, "post_rst");
    release_out("post_rst");

    // Randomized traffic against a transaction-level model:
    // phase 0 idle, 1 decrypting (m_left usable-key cycles to go), 2 holding result
    m_ph = 0; m_left = 0; m_pt = '0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      iv   = ($urandom_range(0, 3) != 0);
      kv   = ($urandom_range(0, 4) != 0);
      ordy = ($urandom_range(0, 2) == 0);
      d    = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.in_valid = iv; bus.key_valid = kv; bus.out_ready = ordy; bus.in_data = d;
      case (m_ph)
        0: if (iv && kv) begin m_pt = inv_cipher(d); m_left = NR; m_ph = 1; end
        1: if (kv) begin m_left--; if (m_left == 0) m_ph = 2; end
        default: if (ordy) m_ph = 0;
      endcase
      @(posedge clk); #1;
      m_ki = (m_ph == 0) ? 4'(NR) : (m_ph == 1) ? 4'(m_left - 1) : 4'd0;
      chk($sformatf("rnd%0d_in_ready", cyc),  128'(bus.in_ready),  128'(m_ph == 0));
      chk($sformatf("rnd%0d_out_valid", cyc), 128'(bus.out_valid), 128'(m_ph == 2));
      chk($sformatf("rnd%0d_busy", cyc),      128'(bus.busy),      128'(m_ph != 0));
      chk($sformatf("rnd%0d_key_idx", cyc),   128'(bus.key_idx),   128'(m_ki));
      chk($sformatf("rnd%0d_dp_last", cyc),   128'(bus.dp_last),   128'(m_ph == 1 && m_left == 1));
      if (m_ph == 2) chk($sformatf("rnd%0d_out_data", cyc), bus.out_data, m_pt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
